// File: rtl/add8_prof_pkg.sv
// Shared types and width helpers for the approximate-adder error profiler.
// Width helpers let parameterised modules derive their bus sizes from OP_W.
package add8_prof_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } prof_state_t;

  localparam int OP_W_DEF = 8;
  localparam int SUM_W    = OP_W_DEF + 1;
  localparam int IDX_W    = 2 * OP_W_DEF;
  localparam int CNT_W    = 2 * OP_W_DEF + 1;

  function automatic int f_sum_w(input int op_w);
    return op_w + 1;
  endfunction

  function automatic int f_idx_w(input int op_w);
    return 2 * op_w;
  endfunction

  function automatic int f_cnt_w(input int op_w);
    return 2 * op_w + 1;
  endfunction

  // Smallest accumulator that cannot overflow over a full sweep.
  function automatic int f_acc_min(input int op_w);
    return 3 * op_w + 1;
  endfunction

endpackage

// File: rtl/add8_prof_err_stage.sv
// Second pipeline stage: absolute error of one sample, then error count,
// absolute-error sum and worst-case error (with its operands) accumulation.
module add8_prof_err_stage
  import add8_prof_pkg::*;
#(
  parameter int OP_W  = 8,
  parameter int ACC_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_en,
  input  logic [f_sum_w(OP_W)-1:0]   i_approx,
  input  logic [f_sum_w(OP_W)-1:0]   i_exact,
  input  logic [OP_W-1:0]            i_a,
  input  logic [OP_W-1:0]            i_b,
  output logic [f_cnt_w(OP_W)-1:0]   o_err_count,
  output logic [ACC_W-1:0]           o_abs_sum,
  output logic [f_sum_w(OP_W)-1:0]   o_wce,
  output logic [OP_W-1:0]            o_wce_a,
  output logic [OP_W-1:0]            o_wce_b
);

  localparam int SW = f_sum_w(OP_W);
  localparam int CW = f_cnt_w(OP_W);

  logic [SW:0]    w_diff;
  logic [SW:0]    w_diff_neg;
  logic [SW-1:0]  w_mag;

  logic [CW-1:0]    r_err_count;
  logic [ACC_W-1:0] r_abs_sum;
  logic [SW-1:0]    r_wce;
  logic [OP_W-1:0]  r_wce_a;
  logic [OP_W-1:0]  r_wce_b;

  // Difference is one bit wider than the sum so its sign is unambiguous.
  assign w_diff     = {1'b0, i_approx} - {1'b0, i_exact};
  assign w_diff_neg = {1'b0, i_exact} - {1'b0, i_approx};
  assign w_mag      = w_diff[SW] ? w_diff_neg[SW-1:0] : w_diff[SW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
      r_abs_sum   <= '0;
      r_wce       <= '0;
      r_wce_a     <= '0;
      r_wce_b     <= '0;
    end else if (i_clear) begin
      r_err_count <= '0;
      r_abs_sum   <= '0;
      r_wce       <= '0;
      r_wce_a     <= '0;
      r_wce_b     <= '0;
    end else if (i_en) begin
      if (w_mag != '0) begin
        r_err_count <= r_err_count + CW'(1);
      end
      r_abs_sum <= r_abs_sum + ACC_W'(w_mag);
      // Strict compare keeps the operands of the first pair hitting the max.
      if (w_mag > r_wce) begin
        r_wce   <= w_mag;
        r_wce_a <= i_a;
        r_wce_b <= i_b;
      end
    end
  end

  assign o_err_count = r_err_count;
  assign o_abs_sum   = r_abs_sum;
  assign o_wce       = r_wce;
  assign o_wce_a     = r_wce_a;
  assign o_wce_b     = r_wce_b;

endmodule

// File: rtl/add8_error_profiler.sv
// Exhaustive error characteriser for an external approximate adder: sweeps
// every operand pair, captures the adder output and accumulates error stats.
module add8_error_profiler
  import add8_prof_pkg::*;
#(
  parameter int OP_W  = 8,
  parameter int ACC_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [OP_W-1:0]       dut_a,
  output logic [OP_W-1:0]       dut_b,
  input  logic [OP_W:0]         dut_o,
  output logic                  busy,
  output logic                  done,
  output logic                  result_valid,
  output logic [2*OP_W:0]       err_count,
  output logic [ACC_W-1:0]      err_abs_sum,
  output logic [OP_W:0]         err_wce,
  output logic [OP_W-1:0]       wce_a,
  output logic [OP_W-1:0]       wce_b
);

  localparam int SW = f_sum_w(OP_W);
  localparam int IW = f_idx_w(OP_W);

  generate
    if (ACC_W < f_acc_min(OP_W)) begin : g_acc_w_too_small
      $error("add8_error_profiler: ACC_W too small for a full sweep");
    end
  endgenerate

  prof_state_t     r_state;
  logic [IW-1:0]   r_idx;
  logic            r_drain;
  logic            r_busy;
  logic            r_done;
  logic            r_result_valid;

  logic            r_s1_valid;
  logic [SW-1:0]   r_s1_approx;
  logic [SW-1:0]   r_s1_exact;
  logic [OP_W-1:0] r_s1_a;
  logic [OP_W-1:0] r_s1_b;

  logic w_start_ok;
  logic w_abort_run;
  logic w_idx_last;

  // Abort beats a simultaneous start; start is only honoured from IDLE.
  assign w_start_ok  = start && !abort && (r_state == ST_IDLE);
  assign w_abort_run = abort && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign w_idx_last  = &r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_drain        <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result_valid <= 1'b0;
      r_s1_valid     <= 1'b0;
      r_s1_approx    <= '0;
      r_s1_exact     <= '0;
      r_s1_a         <= '0;
      r_s1_b         <= '0;
    end else begin
      r_done     <= 1'b0;
      // Stage 1 samples the pair that was on dut_a/dut_b during this cycle.
      r_s1_valid <= (r_state == ST_RUN) && !abort;
      if (r_state == ST_RUN) begin
        r_s1_approx <= dut_o;
        r_s1_exact  <= SW'(r_idx[OP_W-1:0]) + SW'(r_idx[IW-1:OP_W]);
        r_s1_a      <= r_idx[OP_W-1:0];
        r_s1_b      <= r_idx[IW-1:OP_W];
      end

      unique case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state        <= ST_RUN;
            r_idx          <= '0;
            r_busy         <= 1'b1;
            r_result_valid <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_idx_last) begin
            r_state <= ST_DRAIN;
            r_drain <= 1'b0;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_drain) begin
            r_state        <= ST_DONE;
            r_busy         <= 1'b0;
            r_done         <= 1'b1;
            r_result_valid <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  add8_prof_err_stage #(
    .OP_W  (OP_W),
    .ACC_W (ACC_W)
  ) u_err_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_start_ok),
    .i_en        (r_s1_valid && !w_abort_run),
    .i_approx    (r_s1_approx),
    .i_exact     (r_s1_exact),
    .i_a         (r_s1_a),
    .i_b         (r_s1_b),
    .o_err_count (err_count),
    .o_abs_sum   (err_abs_sum),
    .o_wce       (err_wce),
    .o_wce_a     (wce_a),
    .o_wce_b     (wce_b)
  );

  // Operands come straight from the index register, so they hold the last
  // pair after the sweep instead of wrapping.
  assign dut_a        = r_idx[OP_W-1:0];
  assign dut_b        = r_idx[IW-1:OP_W];
  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_add8_error_profiler.sv
// Directed bench for add8_error_profiler at OP_W=4 (256-pair sweeps) with a
// behavioural approximate-adder model selected per sweep.
module tb_add8_error_profiler;

  localparam int OP_W  = 4;
  localparam int ACC_W = 32;
  localparam int LAT   = 258;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [OP_W-1:0]   dut_a;
  logic [OP_W-1:0]   dut_b;
  logic [OP_W:0]     dut_o;
  logic              busy;
  logic              done;
  logic              result_valid;
  logic [2*OP_W:0]   err_count;
  logic [ACC_W-1:0]  err_abs_sum;
  logic [OP_W:0]     err_wce;
  logic [OP_W-1:0]   wce_a;
  logic [OP_W-1:0]   wce_b;

  int n_checks;
  int n_errors;
  int done_pulses;
  int mode;

  add8_error_profiler #(
    .OP_W  (OP_W),
    .ACC_W (ACC_W)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .dut_a        (dut_a),
    .dut_b        (dut_b),
    .dut_o        (dut_o),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .err_count    (err_count),
    .err_abs_sum  (err_abs_sum),
    .err_wce      (err_wce),
    .wce_a        (wce_a),
    .wce_b        (wce_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Approximate adder models: 0 exact, 1 bit0 forced 0, 2 +1, 3 bit4 flipped,
  // 4 zero when sum>=20, 5 zero when sum==7.
  logic [OP_W:0] tb_exact;
  always_comb begin
    tb_exact = {1'b0, dut_a} + {1'b0, dut_b};
    dut_o    = tb_exact;
    case (mode)
      1: dut_o = tb_exact & 5'b11110;
      2: dut_o = tb_exact + 5'd1;
      3: dut_o = tb_exact ^ 5'b10000;
      4: dut_o = (tb_exact >= 5'd20) ? 5'd0 : tb_exact;
      5: dut_o = (tb_exact == 5'd7) ? 5'd0 : tb_exact;
      default: dut_o = tb_exact;
    endcase
  end

  always @(negedge clk) if (done) done_pulses++;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic check_totals(input string tag, input int cnt, input int sum,
                              input int wce, input int a, input int b);
    check_eq({tag, ".err_count"}, 64'(err_count), 64'(cnt));
    check_eq({tag, ".err_abs_sum"}, 64'(err_abs_sum), 64'(sum));
    check_eq({tag, ".err_wce"}, 64'(err_wce), 64'(wce));
    check_eq({tag, ".wce_a"}, 64'(wce_a), 64'(a));
    check_eq({tag, ".wce_b"}, 64'(wce_b), 64'(b));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".busy"}, 64'(busy), 64'd0);
    check_eq({tag, ".done"}, 64'(done), 64'd0);
    check_eq({tag, ".result_valid"}, 64'(result_valid), 64'd0);
    check_eq({tag, ".dut_a"}, 64'(dut_a), 64'd0);
    check_eq({tag, ".dut_b"}, 64'(dut_b), 64'd0);
    check_totals(tag, 0, 0, 0, 0, 0);
  endtask

  // Full sweep; optional start pulses during RUN and during DONE.
  task automatic run_sweep(input string tag, input int m, input bit pulse);
    int cyc;
    int d0;
    bit seen;
    mode = m;
    d0   = done_pulses;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_eq({tag, ".busy_after_start"}, 64'(busy), 64'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 1000) begin
      @(posedge clk);
      #1 cyc++;
      if (pulse && cyc == 50) start = 1'b1;
      if (pulse && cyc == 51) start = 1'b0;
      if (done) seen = 1'b1;
    end
    check_eq({tag, ".latency"}, seen ? 64'(cyc) : 64'hFFFF, 64'(LAT));
    check_eq({tag, ".result_valid_done"}, 64'(result_valid), 64'd1);
    if (pulse) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_eq({tag, ".done_cleared"}, 64'(done), 64'd0);
    check_eq({tag, ".busy_idle"}, 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, ".busy_stays_idle"}, 64'(busy), 64'd0);
    check_eq({tag, ".done_pulses"}, 64'(done_pulses - d0), 64'd1);
    check_eq({tag, ".result_valid_hold"}, 64'(result_valid), 64'd1);
    check_eq({tag, ".dut_a_hold"}, 64'(dut_a), 64'd15);
    check_eq({tag, ".dut_b_hold"}, 64'(dut_b), 64'd15);
  endtask

  initial begin
    int d0;
    n_checks    = 0;
    n_errors    = 0;
    done_pulses = 0;
    mode        = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_all_zero("reset_released");

    run_sweep("exact", 0, 1'b0);
    check_totals("exact", 0, 0, 0, 0, 0);
    run_sweep("bit0", 1, 1'b0);
    check_totals("bit0", 128, 128, 1, 1, 0);
    run_sweep("plus1", 2, 1'b0);
    check_totals("plus1", 256, 256, 1, 0, 0);
    run_sweep("flip4", 3, 1'b0);
    check_totals("flip4", 256, 4096, 16, 0, 0);
    run_sweep("high_zero", 4, 1'b0);
    check_totals("high_zero", 66, 1540, 30, 15, 15);
    run_sweep("tie7", 5, 1'b0);
    check_totals("tie7", 8, 56, 7, 7, 0);

    // Abort partway through RUN
    mode = 1;
    d0   = done_pulses;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_eq("abort.busy_low", 64'(busy), 64'd0);
    repeat (300) @(posedge clk);
    #1;
    check_eq("abort.no_done", 64'(done_pulses - d0), 64'd0);
    check_eq("abort.result_valid", 64'(result_valid), 64'd0);
    check_eq("abort.still_idle", 64'(busy), 64'd0);
    run_sweep("after_abort", 0, 1'b0);
    check_totals("after_abort", 0, 0, 0, 0, 0);

    // start and abort together in IDLE: nothing starts
    d0 = done_pulses;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    check_eq("start_abort.busy", 64'(busy), 64'd0);
    repeat (5) @(posedge clk);
    #1 check_eq("start_abort.no_done", 64'(done_pulses - d0), 64'd0);
    check_eq("start_abort.result_valid", 64'(result_valid), 64'd1);

    // start pulses during RUN and DONE are ignored
    run_sweep("ignored_starts", 1, 1'b1);
    check_totals("ignored_starts", 128, 128, 1, 1, 0);

    // Reset asserted while in DRAIN
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (256) @(posedge clk);
    #1;
    check_eq("drain.busy", 64'(busy), 64'd1);
    check_eq("drain.partial_count", 64'(err_count), 64'd128);
    #3 rst_n = 1'b0;
    #1 check_all_zero("drain_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep("after_reset", 0, 1'b0);
    check_totals("after_reset", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
